// File: rtl/note_player_pkg.sv
// Shared types and the note-to-phase-step table for note_player.
// FREQ_STEP[n] = round(440 * 2^((n-49)/12) * 2^20 / 48000); entry 0 is a rest.
package note_player_pkg;

  localparam int PHASE_W_DEF = 20;
  localparam int NOTE_W      = 6;

  typedef enum logic {
    IDLE    = 1'b0,
    PLAYING = 1'b1
  } state_t;

  typedef logic [PHASE_W_DEF-1:0] step_t;

  localparam step_t FREQ_STEP [64] = '{
    20'd0,     20'd601,   20'd636,   20'd674,   20'd714,   20'd757,   20'd802,   20'd850,
    20'd900,   20'd954,   20'd1010,  20'd1070,  20'd1134,  20'd1201,  20'd1273,  20'd1349,
    20'd1429,  20'd1514,  20'd1604,  20'd1699,  20'd1800,  20'd1907,  20'd2021,  20'd2141,
    20'd2268,  20'd2403,  20'd2546,  20'd2697,  20'd2858,  20'd3028,  20'd3208,  20'd3398,
    20'd3600,  20'd3815,  20'd4041,  20'd4282,  20'd4536,  20'd4806,  20'd5092,  20'd5395,
    20'd5715,  20'd6055,  20'd6415,  20'd6797,  20'd7201,  20'd7629,  20'd8083,  20'd8563,
    20'd9072,  20'd9612,  20'd10184, 20'd10789, 20'd11431, 20'd12110, 20'd12830, 20'd13593,
    20'd14402, 20'd15258, 20'd16165, 20'd17127, 20'd18145, 20'd19224, 20'd20367, 20'd21578
  };

endpackage

// File: rtl/note_player_frequency_rom.sv
// Combinational note index to phase-step lookup.
module frequency_rom
  import note_player_pkg::*;
(
  input  logic [NOTE_W-1:0] note,
  output step_t             step
);

  assign step = FREQ_STEP[note];

endmodule

// File: rtl/note_player.sv
// Sawtooth note player: phase accumulator, beat counter and IDLE/PLAYING FSM.
// Build option NOTE_PLAYER_REST_EN: note 0 outputs silence instead of a constant -32768.
module note_player
  import note_player_pkg::*;
#(
  parameter int PHASE_W  = PHASE_W_DEF,
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play_enable,
  input  logic [NOTE_W-1:0]          note,
  input  logic [NOTE_W-1:0]          duration,
  input  logic                       load_new_note,
  input  logic                       beat,
  input  logic                       generate_next_sample,
  output logic                       done_with_note,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       new_sample_ready
);

  state_t                state_reg, state_next;
  logic [PHASE_W-1:0]    phase_reg, phase_next, phase_sum;
  logic [PHASE_W-1:0]    step_reg, step_next, rom_step;
  logic [NOTE_W-1:0]     count_reg, count_next, count_inc;
  logic [NOTE_W-1:0]     dur_reg, dur_next;
  logic [SAMPLE_W-1:0]   sample_reg, sample_next;
  logic                  ready_reg, ready_next;
  logic                  done_reg, done_next;
  logic                  playing_src;
  step_t                 rom_step_raw;
`ifdef NOTE_PLAYER_REST_EN
  logic                  rest_reg, rest_next;
`endif

  frequency_rom u_frequency_rom (
    .note (note),
    .step (rom_step_raw)
  );

  assign rom_step  = PHASE_W'(rom_step_raw);
  assign count_inc = count_reg + 6'd1;

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (load_new_note)
      state_next = (duration == '0) ? IDLE : PLAYING;
    else if (state_reg == PLAYING && play_enable && beat && count_inc == dur_reg)
      state_next = IDLE;
  end

  // A load coinciding with a sample tick advances from a cleared phase using the new step.
  always_comb begin
    step_next   = step_reg;
    phase_next  = phase_reg;
    count_next  = count_reg;
    dur_next    = dur_reg;
    sample_next = sample_reg;
    ready_next  = 1'b0;
    done_next   = 1'b0;
    phase_sum   = '0;
    playing_src = load_new_note ? (duration != '0) : (state_reg == PLAYING);
`ifdef NOTE_PLAYER_REST_EN
    rest_next   = rest_reg;
`endif

    if (load_new_note) begin
      step_next  = rom_step;
      phase_next = '0;
      count_next = '0;
      dur_next   = duration;
      done_next  = (duration == '0);
`ifdef NOTE_PLAYER_REST_EN
      rest_next  = (note == '0);
`endif
    end else if (state_reg == PLAYING && play_enable && beat) begin
      count_next = count_inc;
      done_next  = (count_inc == dur_reg);
    end

    if (play_enable && generate_next_sample) begin
      ready_next = 1'b1;
      phase_sum  = (load_new_note ? '0 : phase_reg) + (load_new_note ? rom_step : step_reg);
      if (playing_src) begin
        phase_next  = phase_sum;
        sample_next = {~phase_sum[PHASE_W-1], phase_sum[PHASE_W-2 -: SAMPLE_W-1]};
`ifdef NOTE_PLAYER_REST_EN
        if (load_new_note ? (note == '0) : rest_reg) sample_next = '0;
`endif
      end else begin
        sample_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_reg  <= '0;
      step_reg   <= '0;
      count_reg  <= '0;
      dur_reg    <= '0;
      sample_reg <= '0;
      ready_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      phase_reg  <= phase_next;
      step_reg   <= step_next;
      count_reg  <= count_next;
      dur_reg    <= dur_next;
      sample_reg <= sample_next;
      ready_reg  <= ready_next;
      done_reg   <= done_next;
    end
  end

`ifdef NOTE_PLAYER_REST_EN
  always_ff @(posedge clk) begin
    if (!reset) rest_reg <= 1'b0;
    else        rest_reg <= rest_next;
  end
`endif

  assign done_with_note   = done_reg;
  assign sample_out       = sample_reg;
  assign new_sample_ready = ready_reg;

endmodule

// File: tb/tb_note_player.sv
// Directed self-checking bench for note_player; expected samples derived by hand
// from {~phase[19], phase[18:4]} with FREQ_STEP values (A4=9612, note37=4806, note63=21578, note1=601).
module tb_note_player;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              play_enable = 1'b0;
  logic [5:0]        note = '0;
  logic [5:0]        duration = '0;
  logic              load_new_note = 1'b0;
  logic              beat = 1'b0;
  logic              generate_next_sample = 1'b0;
  logic              done_with_note;
  logic signed [15:0] sample_out;
  logic              new_sample_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  note_player dut (
    .clk                  (clk),
    .reset                (reset),
    .play_enable          (play_enable),
    .note                 (note),
    .duration             (duration),
    .load_new_note        (load_new_note),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .done_with_note       (done_with_note),
    .sample_out           (sample_out),
    .new_sample_ready     (new_sample_ready)
  );

  // Apply the currently driven strobes for one edge, then drop them; outputs are sampled 1ns later.
  task automatic step_cycle();
    @(posedge clk);
    #1;
    load_new_note        = 1'b0;
    beat                 = 1'b0;
    generate_next_sample = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      play_enable = 1'b1; note = 6'd49; duration = 6'd1;
      load_new_note = 1'b1; beat = 1'b1; generate_next_sample = 1'b1;
      step_cycle();
      total++;
      if ({sample_out, new_sample_ready, done_with_note} !== 18'd0) begin
        bad++;
        $display("FAIL reset_hold[%0d] sample=%0d ready=%b done=%b want 0/0/0", i, sample_out, new_sample_ready, done_with_note);
      end else $display("reset_hold[%0d] ok", i);
    end
    reset = 1'b1;
    step_cycle();
    generate_next_sample = 1'b1;
    step_cycle();
    total++;
    if (sample_out !== 16'sd0 || new_sample_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_idle_sample sample=%0d ready=%b want 0/1", sample_out, new_sample_ready);
    end else $display("reset_idle_sample ok");
    step_cycle();
    total++;
    if (new_sample_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready_pulse ready=%b want 0", new_sample_ready);
    end else $display("reset_ready_pulse ok");
  endtask

  task automatic test_a4();
    logic signed [15:0] want;
    note = 6'd49; duration = 6'd2; load_new_note = 1'b1;
    step_cycle();
    generate_next_sample = 1'b1;
    step_cycle();
    want = -16'sd32168;
    total++;
    if (sample_out !== want || new_sample_ready !== 1'b1) begin
      bad++;
      $display("FAIL a4_sample1 sample=%0d ready=%b want %0d/1", sample_out, new_sample_ready, want);
    end else $display("a4_sample1 ok %0d", sample_out);
    step_cycle();
    total++;
    if (sample_out !== want || new_sample_ready !== 1'b0) begin
      bad++;
      $display("FAIL a4_hold sample=%0d ready=%b want %0d/0", sample_out, new_sample_ready, want);
    end else $display("a4_hold ok");
    generate_next_sample = 1'b1;
    step_cycle();
    want = -16'sd31567;  // phase 19224
    total++;
    if (sample_out !== want) begin
      bad++;
      $display("FAIL a4_sample2 sample=%0d want %0d", sample_out, want);
    end else $display("a4_sample2 ok %0d", sample_out);
    beat = 1'b1;
    step_cycle();
    total++;
    if (done_with_note !== 1'b0) begin
      bad++;
      $display("FAIL a4_beat1 done=%b want 0", done_with_note);
    end else $display("a4_beat1 ok");
    beat = 1'b1;
    step_cycle();
    total++;
    if (done_with_note !== 1'b1) begin
      bad++;
      $display("FAIL a4_done done=%b want 1", done_with_note);
    end else $display("a4_done ok");
    step_cycle();
    total++;
    if (done_with_note !== 1'b0) begin
      bad++;
      $display("FAIL a4_done_single done=%b want 0", done_with_note);
    end else $display("a4_done_single ok");
  endtask

  task automatic test_pause();
    note = 6'd49; duration = 6'd3; load_new_note = 1'b1;
    step_cycle();
    generate_next_sample = 1'b1;
    step_cycle();
    play_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      beat = 1'b1; generate_next_sample = 1'b1;
      step_cycle();
      total++;
      if (new_sample_ready !== 1'b0 || done_with_note !== 1'b0 || sample_out !== -16'sd32168) begin
        bad++;
        $display("FAIL pause[%0d] ready=%b done=%b sample=%0d want 0/0/-32168", i, new_sample_ready, done_with_note, sample_out);
      end else $display("pause[%0d] ok", i);
    end
    play_enable = 1'b1;
    generate_next_sample = 1'b1;
    step_cycle();
    total++;
    if (sample_out !== -16'sd31567 || new_sample_ready !== 1'b1) begin
      bad++;
      $display("FAIL pause_resume sample=%0d ready=%b want -31567/1", sample_out, new_sample_ready);
    end else $display("pause_resume ok");
    for (int i = 0; i < 3; i++) begin
      beat = 1'b1;
      step_cycle();
      total++;
      if (done_with_note !== (i == 2)) begin
        bad++;
        $display("FAIL pause_beat[%0d] done=%b want %b", i, done_with_note, i == 2);
      end else $display("pause_beat[%0d] ok", i);
    end
  endtask

  task automatic test_override();
    note = 6'd49; duration = 6'd4; load_new_note = 1'b1;
    step_cycle();
    beat = 1'b1;
    step_cycle();
    note = 6'd37; duration = 6'd1; load_new_note = 1'b1;
    step_cycle();
    total++;
    if (done_with_note !== 1'b0) begin
      bad++;
      $display("FAIL override_no_done done=%b want 0", done_with_note);
    end else $display("override_no_done ok");
    generate_next_sample = 1'b1;
    step_cycle();
    total++;
    if (sample_out !== -16'sd32468) begin
      bad++;
      $display("FAIL override_step sample=%0d want -32468", sample_out);
    end else $display("override_step ok");
    beat = 1'b1;
    step_cycle();
    total++;
    if (done_with_note !== 1'b1) begin
      bad++;
      $display("FAIL override_done done=%b want 1", done_with_note);
    end else $display("override_done ok");
    beat = 1'b1;
    step_cycle();
    total++;
    if (done_with_note !== 1'b0) begin
      bad++;
      $display("FAIL override_idle_beat done=%b want 0", done_with_note);
    end else $display("override_idle_beat ok");
  endtask

  task automatic test_zero_duration();
    note = 6'd49; duration = 6'd0; load_new_note = 1'b1;
    step_cycle();
    total++;
    if (done_with_note !== 1'b1) begin
      bad++;
      $display("FAIL zero_dur_done done=%b want 1", done_with_note);
    end else $display("zero_dur_done ok");
    generate_next_sample = 1'b1;
    step_cycle();
    total++;
    if (done_with_note !== 1'b0 || sample_out !== 16'sd0 || new_sample_ready !== 1'b1) begin
      bad++;
      $display("FAIL zero_dur_idle done=%b sample=%0d ready=%b want 0/0/1", done_with_note, sample_out, new_sample_ready);
    end else $display("zero_dur_idle ok");
  endtask

  task automatic test_simultaneous();
    note = 6'd49; duration = 6'd1; load_new_note = 1'b1;
    step_cycle();
    note = 6'd37; duration = 6'd2; load_new_note = 1'b1; beat = 1'b1;
    step_cycle();
    total++;
    if (done_with_note !== 1'b0) begin
      bad++;
      $display("FAIL load_beat_no_done done=%b want 0", done_with_note);
    end else $display("load_beat_no_done ok");
    generate_next_sample = 1'b1;
    step_cycle();
    total++;
    if (sample_out !== -16'sd32468) begin
      bad++;
      $display("FAIL load_beat_new_note sample=%0d want -32468", sample_out);
    end else $display("load_beat_new_note ok");
    note = 6'd49; duration = 6'd1; load_new_note = 1'b1; generate_next_sample = 1'b1;
    step_cycle();
    total++;
    if (sample_out !== -16'sd32168 || new_sample_ready !== 1'b1) begin
      bad++;
      $display("FAIL load_gen sample=%0d ready=%b want -32168/1", sample_out, new_sample_ready);
    end else $display("load_gen ok");
    beat = 1'b1;
    step_cycle();
    total++;
    if (done_with_note !== 1'b1) begin
      bad++;
      $display("FAIL load_gen_done done=%b want 1", done_with_note);
    end else $display("load_gen_done ok");
  endtask

  task automatic test_table_wrap();
    note = 6'd1; duration = 6'd5; load_new_note = 1'b1; generate_next_sample = 1'b1;
    step_cycle();
    total++;
    if (sample_out !== -16'sd32731) begin
      bad++;
      $display("FAIL note1_step sample=%0d want -32731", sample_out);
    end else $display("note1_step ok");
    note = 6'd63; duration = 6'd5; load_new_note = 1'b1;
    step_cycle();
    for (int i = 1; i <= 49; i++) begin
      generate_next_sample = 1'b1;
      step_cycle();
      if (i == 1 || i == 25 || i == 49) begin
        logic signed [15:0] want;
        want = (i == 1) ? -16'sd31420 : (i == 25) ? 16'sd947 : -16'sd32222;
        total++;
        if (sample_out !== want) begin
          bad++;
          $display("FAIL note63_sample[%0d] sample=%0d want %0d", i, sample_out, want);
        end else $display("note63_sample[%0d] ok %0d", i, sample_out);
      end
    end
  endtask

  task automatic test_rest();
    logic signed [15:0] want;
`ifdef NOTE_PLAYER_REST_EN
    want = 16'sd0;
`else
    want = -16'sd32768;
`endif
    note = 6'd0; duration = 6'd2; load_new_note = 1'b1;
    step_cycle();
    for (int i = 0; i < 2; i++) begin
      generate_next_sample = 1'b1; beat = 1'b1;
      step_cycle();
      total++;
      if (sample_out !== want || new_sample_ready !== 1'b1 || done_with_note !== (i == 1)) begin
        bad++;
        $display("FAIL rest[%0d] sample=%0d ready=%b done=%b want %0d/1/%b", i, sample_out, new_sample_ready, done_with_note, want, i == 1);
      end else $display("rest[%0d] ok", i);
    end
  endtask

  task automatic test_reset_midnote();
    note = 6'd49; duration = 6'd1; load_new_note = 1'b1;
    step_cycle();
    reset = 1'b0; beat = 1'b1;
    step_cycle();
    total++;
    if (done_with_note !== 1'b0 || sample_out !== 16'sd0) begin
      bad++;
      $display("FAIL reset_midnote done=%b sample=%0d want 0/0", done_with_note, sample_out);
    end else $display("reset_midnote ok");
    reset = 1'b1; beat = 1'b1;
    step_cycle();
    total++;
    if (done_with_note !== 1'b0) begin
      bad++;
      $display("FAIL reset_abort_beat done=%b want 0", done_with_note);
    end else $display("reset_abort_beat ok");
  endtask

  initial begin
    test_reset();
    test_a4();
    test_pause();
    test_override();
    test_zero_duration();
    test_simultaneous();
    test_table_wrap();
    test_rest();
    test_reset_midnote();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
